// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: collects WIDTH MSB-first beats of a/b and
// reports reassembled words plus greater/equal flags. SERIAL_CMP_SIGNED_EN selects two's complement.
module serial_comparator #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             a_greater,
  output logic             b_greater,
  output logic             ab_equal
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RECV   = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             a_win_q, a_win_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic             a_gt_q, a_gt_d;
  logic             b_gt_q, b_gt_d;
  logic             eq_q, eq_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic accept;
  logic beat_win;

  assign accept = in_valid & in_ready_q;

  // Winner if this beat is the first differing one; the sign beat inverts it.
`ifdef SERIAL_CMP_SIGNED_EN
  assign beat_win = (cnt_q == '0) ? ~a_bit : a_bit;
`else
  assign beat_win = a_bit;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    a_win_d   = a_win_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    out_a_d   = out_a_q;
    out_b_d   = out_b_q;
    a_gt_d    = a_gt_q;
    b_gt_d    = b_gt_q;
    eq_d      = eq_q;

    case (state_q)
      IDLE, RECV: begin
        if (accept) begin
          sh_a_d = {sh_a_q[WIDTH-2:0], a_bit};
          sh_b_d = {sh_b_q[WIDTH-2:0], b_bit};
          if (!decided_q && (a_bit != b_bit)) begin
            decided_d = 1'b1;
            a_win_d   = beat_win;
          end
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = RESULT;
            out_a_d = sh_a_d;
            out_b_d = sh_b_d;
            a_gt_d  = decided_d & a_win_d;
            b_gt_d  = decided_d & ~a_win_d;
            eq_d    = ~decided_d;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = RECV;
          end
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_d   = IDLE;
          decided_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d != RESULT);
    out_valid_d = (state_d == RESULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      decided_q   <= 1'b0;
      a_win_q     <= 1'b0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      a_gt_q      <= 1'b0;
      b_gt_q      <= 1'b0;
      eq_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      decided_q   <= decided_d;
      a_win_q     <= a_win_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      a_gt_q      <= a_gt_d;
      b_gt_q      <= b_gt_d;
      eq_q        <= eq_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign a_greater = a_gt_q;
  assign b_greater = b_gt_q;
  assign ab_equal  = eq_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: word-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_serial_comparator;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         a_bit;
  logic         b_bit;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic         a_greater;
  logic         b_greater;
  logic         ab_equal;

  int n_chk  = 0;
  int n_fail = 0;

  serial_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_bit(a_bit), .b_bit(b_bit), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .a_greater(a_greater), .b_greater(b_greater),
    .ab_equal(ab_equal)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Word-level reference: count accepted beats, compare whole words numerically.
  logic [W-1:0] m_acc_a, m_acc_b, m_a, m_b;
  logic         m_gt, m_lt, m_eq, m_pend;
  int           m_cnt;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_acc_a = '0; m_acc_b = '0; m_a = '0; m_b = '0;
        m_gt = 1'b0; m_lt = 1'b0; m_eq = 1'b0; m_pend = 1'b0; m_cnt = 0;
      end else if (m_pend) begin
        if (out_ready) m_pend = 1'b0;
      end else if (in_valid) begin
        m_acc_a = {m_acc_a[W-2:0], a_bit};
        m_acc_b = {m_acc_b[W-2:0], b_bit};
        m_cnt++;
        if (m_cnt == W) begin
          m_a = m_acc_a;
          m_b = m_acc_b;
`ifdef SERIAL_CMP_SIGNED_EN
          m_gt = ($signed(m_a) > $signed(m_b));
          m_lt = ($signed(m_a) < $signed(m_b));
`else
          m_gt = (m_a > m_b);
          m_lt = (m_a < m_b);
`endif
          m_eq   = (m_a == m_b);
          m_pend = 1'b1;
          m_cnt  = 0;
        end
      end
      @(negedge clk);
      chk("in_ready",  in_ready,  !m_pend);
      chk("out_valid", out_valid, m_pend);
      chk("out_a",     out_a,     m_a);
      chk("out_b",     out_b,     m_b);
      chk("a_greater", a_greater, m_gt);
      chk("b_greater", b_greater, m_lt);
      chk("ab_equal",  ab_equal,  m_eq);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic ab, input logic bb);
    int n;
    in_valid = 1'b1; a_bit = ab; b_bit = bb;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("beat_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a_bit = 1'($urandom); b_bit = 1'($urandom);
  endtask

  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input int maxgap);
    for (int i = W - 1; i >= 0; i--) begin
      beat(a[i], b[i]);
      if (i > 0 && maxgap > 0) idle(int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic take_result(input int hold, input logic busy, input logic lit,
                             input logic [W-1:0] ea, input logic [W-1:0] eb,
                             input logic eg, input logic el, input logic ee);
    int n;
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("result_timeout", 32'd0, 32'd1);
    if (lit) begin
      chk("lit_latency",   n, 0);
      chk("lit_out_a",     out_a, ea);
      chk("lit_out_b",     out_b, eb);
      chk("lit_a_greater", a_greater, eg);
      chk("lit_b_greater", b_greater, el);
      chk("lit_ab_equal",  ab_equal, ee);
    end
    #1;
    in_valid = busy; a_bit = 1'($urandom); b_bit = 1'($urandom);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready",  in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_a",     out_a, 0);
    chk("reset_ab_equal",  ab_equal, 0);
    @(posedge clk); #1;

    send_word(4'hA, 4'h7, 0);
    take_result(0, 1'b0, 1'b1, 4'hA, 4'h7, 1'b1, 1'b0, 1'b0);

    send_word(4'h6, 4'h6, 0);
    take_result(0, 1'b0, 1'b1, 4'h6, 4'h6, 1'b0, 1'b0, 1'b1);

    beat(1'b0, 1'b0); idle(1);
    beat(1'b0, 1'b1); idle(2);
    beat(1'b1, 1'b0); idle(1);
    beat(1'b1, 1'b1);
    take_result(0, 1'b0, 1'b1, 4'h3, 4'h5, 1'b0, 1'b1, 1'b0);

    send_word(4'h9, 4'h3, 0);
    take_result(3, 1'b1, 1'b1, 4'h9, 4'h3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_after_hs_ready", in_ready, 1);
    chk("idle_after_hs_valid", out_valid, 0);
    chk("hold_after_hs_out_a", out_a, 4'h9);
    @(posedge clk); #1;

    beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    rst = 1'b1; in_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    send_word(4'h1, 4'h2, 0);
    take_result(0, 1'b0, 1'b1, 4'h1, 4'h2, 1'b0, 1'b1, 1'b0);

    send_word(4'h8, 4'h1, 0);
`ifdef SERIAL_CMP_SIGNED_EN
    take_result(0, 1'b0, 1'b1, 4'h8, 4'h1, 1'b0, 1'b1, 1'b0);
`else
    take_result(0, 1'b0, 1'b1, 4'h8, 4'h1, 1'b1, 1'b0, 1'b0);
`endif

    repeat (40) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      send_word(ra, rb, 2);
      take_result(int'($urandom_range(0, 3)), 1'($urandom), 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
